irq_hub: RTL and testbench

Memory-mapped interrupt collector that sits between the peripheral interrupt sources (the timers' `IRQ` outputs and the external interrupt generator) and CP0's `HWInt[5:0]` input. It synchronises each source and latches it as level-following or edge-sticky per a software-programmed mode bit. It masks the pending set and exposes pending, active and lowest-index-active status through a four-word register window on the system bridge.

---
 rtl/irq_pkg.sv | 25 ++
 rtl/irq_edge_sync.sv | 24 ++
 rtl/irq_hub.sv | 77 +++++++
 tb/tb_irq_hub.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/irq_pkg.sv
// irq_pkg: shared constants for the interrupt hub (register map, source indices, ACTIVE fields).
package irq_pkg;

    localparam int NUM_SRC_DEF = 6;

    localparam logic [1:0] IRQ_MODE   = 2'd0;
    localparam logic [1:0] IRQ_MASK   = 2'd1;
    localparam logic [1:0] IRQ_PEND   = 2'd2;
    localparam logic [1:0] IRQ_ACTIVE = 2'd3;

    localparam int SRC_TIMER0 = 0;
    localparam int SRC_TIMER1 = 1;
    localparam int SRC_IG     = 2;

    localparam int ACT_IDX_LSB = 8;
    localparam int ACT_IDX_MSB = 10;
    localparam int ACT_ANY_BIT = 15;

    function automatic logic [2:0] lowest_set(input logic [5:0] v);
        lowest_set = 3'd0;
        for (int k = 5; k >= 0; k--)
            if (v[k]) lowest_set = 3'(k);
    endfunction

endpackage

// File: rtl/irq_edge_sync.sv
// irq_edge_sync: one-flop source synchroniser plus delayed copy for rising-edge detection.
module irq_edge_sync (
    input  logic clk,
    input  logic reset,
    input  logic src,
    output logic sync,
    output logic rise
);

    logic prev;

    always_ff @(posedge clk) begin
        if (!reset) begin
            sync <= 1'b0;
            prev <= 1'b0;
        end else begin
            sync <= src;
            prev <= sync;
        end
    end

    assign rise = sync & ~prev;

endmodule

// File: rtl/irq_hub.sv
// irq_hub: collects peripheral interrupts as level or sticky-edge pending bits, masks them
// into HWInt and exposes MODE/MASK/PENDING/ACTIVE through a four-word register window.
module irq_hub
    import irq_pkg::*;
#(
    parameter int NUM_SRC = NUM_SRC_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [31:2]        Addr,
    input  logic               WE,
    input  logic [31:0]        Din,
    output logic [31:0]        Dout,
    input  logic [NUM_SRC-1:0] irq_src,
    output logic [5:0]         HWInt,
    output logic               irq_any
);

    localparam logic [5:0] VALID = 6'((1 << NUM_SRC) - 1);

    logic [5:0] sync, rise, mode, mask, pend, pend_n, clr, active;
    logic [1:0] idx;
    logic [2:0] low;

    for (genvar i = 0; i < 6; i++) begin : g_src
        if (i < NUM_SRC) begin : g_used
            irq_edge_sync u_sync (
                .clk  (clk),
                .reset(reset),
                .src  (irq_src[i]),
                .sync (sync[i]),
                .rise (rise[i])
            );
        end else begin : g_tie
            assign sync[i] = 1'b0;
            assign rise[i] = 1'b0;
        end
    end

    assign idx = Addr[3:2];
    assign clr = (WE && idx == IRQ_PEND) ? Din[5:0] : 6'd0;

    // Edge bits: a rise wins over a same-cycle clear so no edge is lost.
    assign pend_n = (mode & (rise | (pend & ~clr))) | (~mode & sync);

    always_ff @(posedge clk) begin
        if (!reset) begin
            mode <= 6'd0;
            mask <= 6'd0;
            pend <= 6'd0;
        end else begin
            mode <= (WE && idx == IRQ_MODE) ? Din[5:0] & VALID : mode;
            mask <= (WE && idx == IRQ_MASK) ? Din[5:0] & VALID : mask;
            pend <= pend_n & VALID;
        end
    end

    assign active  = pend & mask;
    assign HWInt   = active;
    assign irq_any = |active;
    assign low     = lowest_set(active);

    always_comb begin
        Dout = (idx == IRQ_MODE) ? {26'd0, mode} :
               (idx == IRQ_MASK) ? {26'd0, mask} :
               (idx == IRQ_PEND) ? {26'd0, pend} :
                                   {26'd0, active};
        if (idx == IRQ_ACTIVE) begin
            Dout[ACT_IDX_MSB:ACT_IDX_LSB] = low;
            Dout[ACT_ANY_BIT]             = irq_any;
        end
    end

    logic unused;
    assign unused = &{1'b0, Addr[31:4], Din[31:6]};

endmodule

// File: tb/tb_irq_hub.sv
// tb_irq_hub: directed test-plan scenarios plus randomized traffic checked against a behavioural model.
module tb_irq_hub;
    import irq_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:2] addr = '0;
    logic        we = 1'b0;
    logic [31:0] din = '0;
    logic [31:0] dout;
    logic [5:0]  src = '0;
    logic [5:0]  hwint;
    logic        irq_any;

    int total = 0;
    int bad = 0;

    // Model: register contents plus the source value seen at the last two edges.
    logic [5:0] m_mode, m_mask, m_pend, seen1, seen2;

    always #5 clk = ~clk;

    irq_hub dut (
        .clk    (clk),
        .reset  (reset),
        .Addr   (addr),
        .WE     (we),
        .Din    (din),
        .Dout   (dout),
        .irq_src(src),
        .HWInt  (hwint),
        .irq_any(irq_any)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] model_read(input logic [1:0] a);
        logic [5:0] act;
        logic [2:0] first;
        act = m_pend & m_mask;
        first = 3'd0;
        for (int i = 5; i >= 0; i--) if (act[i]) first = 3'(i);
        case (a)
            2'd0: return {26'd0, m_mode};
            2'd1: return {26'd0, m_mask};
            2'd2: return {26'd0, m_pend};
            default: return {16'd0, act != 6'd0, 4'd0, first, 2'd0, act};
        endcase
    endfunction

    task automatic model_edge();
        if (!reset) begin
            m_mode = 0; m_mask = 0; m_pend = 0; seen1 = 0; seen2 = 0;
            return;
        end
        for (int i = 0; i < 6; i++) begin
            if (!m_mode[i]) m_pend[i] = seen1[i];
            else if (seen1[i] && !seen2[i]) m_pend[i] = 1'b1;
            else if (we && addr[3:2] == 2'd2 && din[i]) m_pend[i] = 1'b0;
        end
        if (we && addr[3:2] == 2'd0) m_mode = din[5:0];
        if (we && addr[3:2] == 2'd1) m_mask = din[5:0];
        seen2 = seen1;
        seen1 = src;
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        chk("hwint", {26'd0, hwint}, {26'd0, m_pend & m_mask});
        chk("irq_any", {31'd0, irq_any}, {31'd0, (m_pend & m_mask) != 0});
        chk("dout", dout, model_read(addr[3:2]));
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        addr = {28'd0, a}; din = d; we = 1'b1;
        tick();
        we = 1'b0;
    endtask

    task automatic rd(input logic [1:0] a, input string tag, input logic [31:0] exp);
        addr = {28'd0, a};
        #1;
        chk(tag, dout, exp);
    endtask

    initial begin
        m_mode = 0; m_mask = 0; m_pend = 0; seen1 = 0; seen2 = 0;
        reset = 1'b0;
        tick(); tick();
        reset = 1'b1;
        tick();
        rd(IRQ_MODE, "rst_mode", 0);
        rd(IRQ_MASK, "rst_mask", 0);
        rd(IRQ_PEND, "rst_pend", 0);
        rd(IRQ_ACTIVE, "rst_active", 0);
        chk("rst_hwint", {26'd0, hwint}, 0);

        // Level mode latency: high before edge N, HWInt after N+1.
        wr(IRQ_MASK, 32'h3F);
        wr(IRQ_MODE, 32'h0);
        src = 6'h01;
        tick();
        chk("lvl_n", {26'd0, hwint}, 0);
        src = 6'h00;
        tick();
        chk("lvl_n1", {26'd0, hwint}, 32'h01);
        tick();
        chk("lvl_drop", {26'd0, hwint}, 0);

        // Edge mode: one-cycle pulse latched, then W1C.
        wr(IRQ_MODE, 32'h02);
        wr(IRQ_MASK, 32'h02);
        src = 6'h02; tick();
        src = 6'h00; tick(); tick(); tick(); tick();
        rd(IRQ_PEND, "edge_held", 32'h02);
        wr(IRQ_PEND, 32'h02);
        chk("edge_w1c", {26'd0, hwint}, 0);
        tick();

        // W1C coinciding with a fresh rise leaves the bit set.
        src = 6'h02; tick(); tick();
        src = 6'h00; tick(); tick();
        src = 6'h02; tick();
        wr(IRQ_PEND, 32'h02);
        chk("w1c_vs_rise", {26'd0, hwint}, 32'h02);
        src = 6'h00;

        // ACTIVE encoding.
        wr(IRQ_MODE, 32'h0);
        src = 6'h05;
        wr(IRQ_MASK, 32'h04);
        tick(); tick();
        rd(IRQ_ACTIVE, "active_m4", 32'h00008204);
        wr(IRQ_MASK, 32'h05);
        rd(IRQ_ACTIVE, "active_m5", 32'h00008005);

        // Mid-operation reset clears sticky bits.
        src = 6'h00;
        wr(IRQ_MODE, 32'h08);
        wr(IRQ_MASK, 32'h3F);
        src = 6'h08; tick();
        src = 6'h00; tick(); tick();
        chk("pre_rst_pend", {26'd0, hwint}, 32'h08);
        reset = 1'b0;
        addr = {28'd0, IRQ_MASK}; din = 32'h3F; we = 1'b1;
        tick();
        we = 1'b0;
        reset = 1'b1;
        chk("rst_hw", {26'd0, hwint}, 0);
        rd(IRQ_MODE, "rst2_mode", 0);
        rd(IRQ_MASK, "rst2_mask", 0);
        rd(IRQ_PEND, "rst2_pend", 0);

        // Randomized traffic.
        for (int n = 0; n < 3000; n++) begin
            src = 6'($urandom);
            we = ($urandom_range(0, 3) == 0);
            addr = 30'($urandom);
            din = $urandom;
            reset = ($urandom_range(0, 99) != 0);
            tick();
        end
        reset = 1'b1;
        we = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
